// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster-scan timing source with registered RGB/sync and a bouncing delt animation
//   clk, rst          pixel clock, synchronous active-high reset
//   anim_en           allows the delt update on the last pixel of a frame
//   hit_a, hit_b      painter hit flags, combinational from x/y/delt
//   x, y              current h/v counters, zero-extended to 11 bits
//   delt              animation offset, constant for a whole frame
//   hs, vs            active-low syncs, one cycle after x/y
//   r, g, b           pixel colour, one cycle after x/y
//   frame_start       high while x=0,y=0 is presented at the start of a frame
module vga_scan_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int DELT_MAX = 100,
  parameter int DELT_STEP = 2,
  parameter logic [8:0] FG = 9'b111_111_000,
  parameter logic [8:0] BG = 9'b000_000_011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        anim_en,
  input  logic        hit_a,
  input  logic        hit_b,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [10:0] delt,
  output logic        hs,
  output logic        vs,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [2:0]  b,
  output logic        frame_start
);
  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] HS0 = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] HM = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] VS0 = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] VM = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [10:0] DM = 11'(DELT_MAX);
  localparam logic [10:0] DS = 11'(DELT_STEP);
  logic [10:0] h_cnt, v_cnt, delt_n;
  logic [8:0] rgb, rgb_n;
  logic dir, dir_n, run, h_end, f_end, active, up_sat, dn_sat;
  assign x = h_cnt;
  assign y = v_cnt;
  assign {r, g, b} = rgb;
  always_comb begin
    h_end = h_cnt == HM;
    f_end = h_end && v_cnt == VM;
    active = h_cnt < HA && v_cnt < VA;
    rgb_n = !active ? 9'd0 : (hit_a | hit_b) ? FG : BG;
    up_sat = delt + DS >= DM;
    dn_sat = delt <= DS;
    delt_n = dir ? (dn_sat ? 11'd0 : delt - DS) : (up_sat ? DM : delt + DS);
    dir_n = dir ? !dn_sat : up_sat;
  end
  // run holds the counters at (0,0) for one extra cycle after reset so that
  // the origin is presented together with the frame_start pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
      delt <= 11'd0;
      dir <= 1'b0;
      run <= 1'b0;
      frame_start <= 1'b0;
      hs <= 1'b1;
      vs <= 1'b1;
      rgb <= 9'd0;
    end else begin
      run <= 1'b1;
      frame_start <= !run || f_end;
      hs <= !(h_cnt >= HS0 && h_cnt < HS1);
      vs <= !(v_cnt >= VS0 && v_cnt < VS1);
      rgb <= rgb_n;
      if (run) begin
        h_cnt <= h_end ? 11'd0 : h_cnt + 11'd1;
        if (h_end) v_cnt <= f_end ? 11'd0 : v_cnt + 11'd1;
        if (f_end && anim_en) begin
          delt <= delt_n;
          dir <= dir_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_vga_scan_driver.sv
// tb_vga_scan_driver: directed checks of scan timing, colour alignment, animation and reset
module tb_vga_scan_driver;
  localparam logic [8:0] FG = 9'b111_111_000;
  localparam logic [8:0] BG = 9'b000_000_011;
  localparam logic [44:0] RST_V = {33'd0, 2'b11, 10'd0};
  logic clk = 1'b0, rst = 1'b1, anim_en = 1'b1, hit_a = 1'b0, hit_b = 1'b0;
  logic [10:0] x0, y0, d0, x1, y1, d1, x2, y2, d2;
  logic hs0, vs0, fs0, hs1, vs1, fs1, hs2, vs2, fs2;
  logic [2:0] r0, g0, b0, r1, g1, b1, r2, g2, b2;
  int n_cmp = 0, n_bad = 0;
  int bad_x, bad_c, lo, first, nfs, runs, lo_v, last_fs, bad_fs, f1, f2, bad_a, bad_b, e1;
  logic prev_vs;
  logic [8:0] exp_c;
  int tbl[8] = '{0, 2, 4, 5, 3, 1, 0, 2};
  always #5 clk = ~clk;
  // u0: full-width lines, short frames; u1/u2: tiny raster for fast animation runs
  vga_scan_driver #(.V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u0 (
    .clk(clk), .rst(rst), .anim_en(anim_en), .hit_a(hit_a), .hit_b(hit_b),
    .x(x0), .y(y0), .delt(d0), .hs(hs0), .vs(vs0), .r(r0), .g(g0), .b(b0), .frame_start(fs0));
  vga_scan_driver #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)) u1 (
    .clk(clk), .rst(rst), .anim_en(anim_en), .hit_a(hit_a), .hit_b(hit_b),
    .x(x1), .y(y1), .delt(d1), .hs(hs1), .vs(vs1), .r(r1), .g(g1), .b(b1), .frame_start(fs1));
  vga_scan_driver #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .DELT_MAX(5), .DELT_STEP(2)) u2 (
    .clk(clk), .rst(rst), .anim_en(anim_en), .hit_a(hit_a), .hit_b(hit_b),
    .x(x2), .y(y2), .delt(d2), .hs(hs2), .vs(vs2), .r(r2), .g(g2), .b(b2), .frame_start(fs2));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    step(2);
    chk("rst_u0", {x0, y0, d0, hs0, vs0, r0, g0, b0, fs0}, RST_V);
    chk("rst_u1", {x1, y1, d1, hs1, vs1, r1, g1, b1, fs1}, RST_V);
    chk("rst_u2", {x2, y2, d2, hs2, vs2, r2, g2, b2, fs2}, RST_V);
    rst = 1'b0;
    step(1);
    chk("first_cycle", {x0, y0, fs0}, {11'd0, 11'd0, 1'b1});
    bad_x = 0; bad_c = 0; lo = 0; first = -1;
    for (int k = 0; k < 800; k++) begin
      if (x0 !== 11'(k)) bad_x++;
      if (!hs0) begin
        lo++;
        if (first < 0) first = k;
      end
      if (k >= 1 && {r0, g0, b0} !== (k <= 640 ? BG : 9'd0)) bad_c++;
      step(1);
    end
    chk("x_ramp", bad_x, 0);
    chk("rgb_bg", bad_c, 0);
    chk("hs_width", lo, 96);
    chk("hs_start", first, 657);
    chk("line_wrap", {x0, y0}, {11'd0, 11'd1});
    bad_c = 0;
    for (int k = 0; k < 800; k++) begin
      hit_a = k < 320;
      hit_b = k >= 600 && k < 700;
      exp_c = (k == 0 || k > 640) ? 9'd0 : (k - 1 < 320 || k - 1 >= 600) ? FG : BG;
      if ({r0, g0, b0} !== exp_c) bad_c++;
      if (k == 320) chk("fg_edge_a", {r0, g0, b0}, FG);
      if (k == 321) chk("bg_after_a", {r0, g0, b0}, BG);
      if (k == 640) chk("fg_last_x640", {r0, g0, b0}, FG);
      if (k == 641) chk("blank_x641", {r0, g0, b0}, 9'd0);
      step(1);
    end
    hit_a = 1'b0;
    hit_b = 1'b0;
    chk("rgb_hits", bad_c, 0);
    nfs = 0; runs = 0; lo_v = 0; last_fs = -1; bad_fs = 0; prev_vs = 1'b1;
    for (int c = 1600; c < 17600; c++) begin
      if (!vs0) begin
        lo_v++;
        if (prev_vs) runs++;
      end
      prev_vs = vs0;
      if (fs0) begin
        nfs++;
        if ({x0, y0} !== 22'd0) bad_fs++;
        if (nfs == 2) chk("fs_period", c - last_fs, 8000);
        last_fs = c;
      end
      step(1);
    end
    chk("vs_low", lo_v, 3200);
    chk("vs_runs", runs, 2);
    chk("fs_count", nfs, 2);
    chk("fs_origin", bad_fs, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    f1 = -1; f2 = -1; bad_a = 0; bad_b = 0; bad_fs = 0;
    for (int c = 0; c < 14000; c++) begin
      anim_en = (c / 250 <= 50 || c / 250 >= 54) ? (c % 250 != 100) : (c % 250 == 100);
      if (fs1) f1++;
      if (fs2) f2++;
      e1 = f1 <= 50 ? 2 * f1 : f1 <= 54 ? 98 : 96;
      if (d1 !== 11'(e1)) bad_a++;
      if (f2 < 8 && d2 !== 11'(tbl[f2])) bad_b++;
      if (fs1 !== (c % 250 == 0)) bad_fs++;
      step(1);
    end
    chk("delt_seq", bad_a, 0);
    chk("delt_small", bad_b, 0);
    chk("fs_small", bad_fs, 0);
    chk("frames_u1", f1, 55);
    chk("frames_u2", f2, 55);
    chk("delt_after", d1, 11'd94);
    step(310);
    chk("pre_u1", {x1, y1, d1, r1, g1, b1}, {11'd10, 11'd2, 11'd92, BG});
    chk("pre_u0", {x0, y0, hs0, vs0}, {11'd710, 11'd7, 1'b0, 1'b0});
    rst = 1'b1;
    step(1);
    chk("mid_rst_u0", {x0, y0, d0, hs0, vs0, r0, g0, b0, fs0}, RST_V);
    chk("mid_rst_u1", {x1, y1, d1, hs1, vs1, r1, g1, b1, fs1}, RST_V);
    chk("mid_rst_u2", {x2, y2, d2, hs2, vs2, r2, g2, b2, fs2}, RST_V);
    rst = 1'b0;
    step(1);
    chk("restart", {x1, y1, fs1}, {11'd0, 11'd0, 1'b1});
    step(249);
    chk("pre_end", {x1, y1, d1}, {11'd24, 11'd9, 11'd0});
    rst = 1'b1;
    step(1);
    chk("rst_wins", {x1, y1, d1, d2, fs1}, 34'd0);
    rst = 1'b0;
    step(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
